dmem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-port data memory (DEPTH x 32-bit words, combinational read, write on mem_we).
- Shares the memory between the CPU load/store port (p0) and a loader/debug port (p1).
- Registers each accepted command and drives the memory for exactly one cycle.
- Returns read data or a write acknowledgment with fixed latency.
- Rejects misaligned and out-of-range accesses with an error response.

---
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if -- one requester port of the data-memory arbiter.
//
// Command side (requester -> arbiter):
//   req    request; held with the other fields stable until gnt at a clock edge
//   we     1 = write, 0 = read
//   addr   byte address (AW bits)
//   wdata  write data (DW bits)
//   lock   keep the arbiter locked to this port (only with DMEM_ARB_LOCK_EN)
// Response side (arbiter -> requester):
//   gnt    command accepted this cycle (combinational)
//   rvalid one-cycle response pulse, two cycles after gnt
//   rdata  read data (0 for writes and errors), valid with rvalid
//   err    misaligned / out-of-range access, valid with rvalid
//
// Build option: define DMEM_ARB_LOCK_EN to add the lock signal.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
`ifdef DMEM_ARB_LOCK_EN
  logic          lock;
`endif
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

`ifdef DMEM_ARB_LOCK_EN
  modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid, rdata, err);
`else
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter -- two-port arbiter / sequencer in front of a single-port
// data memory (DEPTH x DW words, combinational read, write on mem_we).
//
// Pipeline (one access per cycle):
//   N   : winner gets gnt, command registered at the end of N
//   N+1 : memory driven from the registered command, mem_rdata captured
//   N+2 : owner's rvalid pulses (writes acknowledge with rdata = 0)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   p0, p1     requester ports (dmem_arbiter_if.slave); p0 = CPU, p1 = loader
//   mem_we     memory write enable (only for valid, non-errored writes)
//   mem_addr   memory word index, zero-extended to AW bits
//   mem_wdata  memory write data
//   mem_rdata  memory read data, combinational from mem_addr
//
// Parameters: AW, DW, DEPTH (power of 2), FIXED_PRI (0 = round-robin,
// 1 = p0 always wins a contention).
//
// Build option: DMEM_ARB_LOCK_EN adds per-port lock; a grant with lock=1
// pins the arbiter to that port until it issues a lock=0 command or drops req.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DEPTH     = 128,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  dmem_arbiter_if.slave p0,
  dmem_arbiter_if.slave p1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t state_reg, state_next;
  logic   last_winner_reg, last_winner_next;
  logic   gnt_p0, gnt_p1;

  // Registered command (memory stage)
  logic          cmd_valid_reg;
  logic          cmd_port_reg;
  logic          cmd_we_reg;
  logic          cmd_err_reg;
  logic [IW-1:0] cmd_idx_reg;
  logic [DW-1:0] cmd_wdata_reg;

  // Registered response (return stage)
  logic          rsp_valid_reg;
  logic          rsp_port_reg;
  logic          rsp_err_reg;
  logic [DW-1:0] rsp_data_reg;

  // Per-port address decode
  logic [AW-1:0] addr_arr [2];
  logic [IW-1:0] idx_arr  [2];
  logic [1:0]    err_vec;
  logic [1:0]    rvalid_vec;

  assign addr_arr[0] = p0.addr;
  assign addr_arr[1] = p1.addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign idx_arr[gi] = addr_arr[gi][IW+1:2];
      // Anything at or above 4*DEPTH has a nonzero bit above the word index.
      assign err_vec[gi] = (addr_arr[gi][1:0] != 2'b00) ||
                           ((addr_arr[gi] >> (IW + 2)) != '0);
      assign rvalid_vec[gi] = rsp_valid_reg && (rsp_port_reg == 1'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Arbitration FSM: next state, grants, last winner
  // -------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    last_winner_next = last_winner_reg;
    gnt_p0           = 1'b0;
    gnt_p1           = 1'b0;
    case (state_reg)
`ifdef DMEM_ARB_LOCK_EN
      LOCK0: begin
        // Only p0 may be served; any exit hands priority to p1 next time.
        if (p0.req) begin
          gnt_p0 = 1'b1;
        end
        if (!p0.req || !p0.lock) begin
          state_next       = ARB;
          last_winner_next = 1'b0;
        end
      end
      LOCK1: begin
        if (p1.req) begin
          gnt_p1 = 1'b1;
        end
        if (!p1.req || !p1.lock) begin
          state_next       = ARB;
          last_winner_next = 1'b1;
        end
      end
`endif
      default: begin
        state_next = ARB;
        if (p0.req && p1.req) begin
          if ((FIXED_PRI != 0) || last_winner_reg) begin
            gnt_p0 = 1'b1;
          end else begin
            gnt_p1 = 1'b1;
          end
        end else if (p0.req) begin
          gnt_p0 = 1'b1;
        end else if (p1.req) begin
          gnt_p1 = 1'b1;
        end
        if (gnt_p0) begin
          last_winner_next = 1'b0;
        end
        if (gnt_p1) begin
          last_winner_next = 1'b1;
        end
`ifdef DMEM_ARB_LOCK_EN
        if (gnt_p0 && p0.lock) begin
          state_next = LOCK0;
        end
        if (gnt_p1 && p1.lock) begin
          state_next = LOCK1;
        end
`endif
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and pipeline registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ARB;
      last_winner_reg <= 1'b1;
      cmd_valid_reg   <= 1'b0;
      cmd_port_reg    <= 1'b0;
      cmd_we_reg      <= 1'b0;
      cmd_err_reg     <= 1'b0;
      cmd_idx_reg     <= '0;
      cmd_wdata_reg   <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_port_reg    <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_data_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      last_winner_reg <= last_winner_next;

      cmd_valid_reg <= gnt_p0 || gnt_p1;
      // Command fields only move on a grant so mem_addr/mem_wdata hold
      // their last values while the memory stage is idle.
      if (gnt_p0 || gnt_p1) begin
        cmd_port_reg  <= gnt_p1;
        cmd_we_reg    <= gnt_p1 ? p1.we : p0.we;
        cmd_err_reg   <= gnt_p1 ? err_vec[1] : err_vec[0];
        cmd_idx_reg   <= gnt_p1 ? idx_arr[1] : idx_arr[0];
        cmd_wdata_reg <= gnt_p1 ? p1.wdata : p0.wdata;
      end

      rsp_valid_reg <= cmd_valid_reg;
      rsp_port_reg  <= cmd_port_reg;
      rsp_err_reg   <= cmd_err_reg;
      rsp_data_reg  <= (cmd_valid_reg && !cmd_we_reg && !cmd_err_reg) ? mem_rdata : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_we    = cmd_valid_reg && cmd_we_reg && !cmd_err_reg;
  assign mem_addr  = {{(AW - IW){1'b0}}, cmd_idx_reg};
  assign mem_wdata = cmd_wdata_reg;

  assign p0.gnt    = gnt_p0;
  assign p1.gnt    = gnt_p1;
  assign p0.rvalid = rvalid_vec[0];
  assign p1.rvalid = rvalid_vec[1];
  // Response data/err are forced to 0 on the port that is not being answered.
  assign p0.rdata  = rvalid_vec[0] ? rsp_data_reg : '0;
  assign p1.rdata  = rvalid_vec[1] ? rsp_data_reg : '0;
  assign p0.err    = rvalid_vec[0] && rsp_err_reg;
  assign p1.err    = rvalid_vec[1] && rsp_err_reg;

endmodule
